mx8_rr_arbiter: RTL and testbench
=================================

Name: mx8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-to-1 1-bit mux channel between 8 requesters.
- Produces a one-hot grant plus the 3-bit mux select (sel[2] -> s2, sel[1] -> s1, sel[0] -> s0).
- Holds the grant until the owner releases, drops its request, or hits a hold timeout.
- Sits between requesting units and the shared mx8 select inputs in the alu4 datapath.

Parameters:
- HOLD_MAX, default 15: maximum cycles one owner may hold the grant; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  8  request vector; req[i] = requester i wants the mux
- release  input  1  current owner ends its use; ignored when no grant is active
- gnt  output  8  one-hot grant, registered; all-zero when idle
- sel  output  3  binary index of the owner, registered; drives s2..s0 of the mux
- busy  output  1  registered; equals |gnt
- timeout  output  1  one-cycle pulse, registered; grant was revoked by HOLD_MAX

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high.
  - Reset values: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
  - Reset asserted mid-grant: all reset values apply at the next edge. No partial release and no timeout pulse.
- State machine: IDLE and GRANT.
- IDLE
  - If req!=0, pick the first i with req[i]=1, scanning ptr, ptr+1, ... mod 8.
  - Next edge: gnt=onehot(i), sel=i, busy=1, hold_cnt=0, state=GRANT. Grant latency is 1 cycle after the req edge.
  - If req==0, remain in IDLE. sel keeps its last value and gnt=0.
- GRANT (owner = sel)
  - End condition E: release=1, or req[owner]=0, or (HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1).
  - While E is false: hold_cnt+1 each cycle. gnt and sel are stable.
  - When E is true:
    - ptr <= (owner+1) mod 8.
    - Arbitrate the same cycle over req & ~onehot(owner), starting from the new ptr.
    - Winner found: grant it at the next edge, with no idle bubble and hold_cnt=0.
    - No winner: go to IDLE with gnt=0 and busy=0.
  - timeout=1 for exactly one cycle only when E was caused solely by the hold limit. If release or a dropped request coincides with the limit, timeout=0.
  - A sole requester that re-requests after its release/timeout gets one IDLE cycle and is then re-granted.
- Pointer and width rules
  - ptr is 3 bits and wraps 7 -> 0.
  - hold_cnt is max(1,$clog2(HOLD_MAX+1)) bits and never exceeds HOLD_MAX-1.
- Invariants
  - gnt is always zero or one-hot.
  - gnt!=0 implies gnt==onehot(sel).
  - Requests arriving mid-grant never preempt the owner.

Decomposition:
- Shared package holds:
  - constants NREQ=8 and SEL_W=3
  - state encoding IDLE=1'b0, GRANT=1'b1
- One sub-module: rr_pick8, purely combinational.
  - Inputs: req[7:0], ptr[2:0], mask[7:0].
  - Outputs: found, idx[2:0].
  - Rotate, priority-encode, un-rotate.

Test Plan:
- Reset, then req=8'b0000_0001 -> next cycle gnt=8'h01, sel=0, busy=1; release=1 -> next cycle gnt=0, ptr=1.
- req=8'hFF, release pulsed each grant -> grants 0,1,2,...,7,0 in order, back-to-back, with no idle cycle between them.
- HOLD_MAX=15, req=8'h24 held, no release -> gnt=8'h04 for 15 cycles, timeout pulse, then gnt=8'h20, sel=5.
- Owner 3 drops req[3] while req[6]=1 -> next edge gnt=8'h40, sel=6, timeout=0.
- Sole requester 7, timeout hit -> one IDLE cycle (gnt=0), then gnt=8'h80 again; ptr wrapped to 0.
- reset=1 during GRANT with hold_cnt=9 -> next edge gnt=0, sel=0, busy=0, timeout=0, ptr=0.

Source files
------------

// File: rtl/mx8_rr_arbiter_pkg.sv
// mx8_rr_arbiter_pkg: shared constants, state encoding and one-hot helper for the mx8 arbiter
package mx8_rr_arbiter_pkg;
  localparam int NREQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/mx8_rr_arbiter_pick8.sv
// rr_pick8: rotate masked requests by ptr, take lowest set bit, un-rotate to an absolute index
module rr_pick8
  import mx8_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [NREQ-1:0] m;
  logic [2*NREQ-1:0] dbl;
  logic [SEL_W-1:0] off;
  assign m = req & mask;
  assign dbl = {m, m} >> ptr;
  assign found = |m;
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (dbl[i]) off = SEL_W'(i);
  end
  assign idx = off + ptr;
endmodule

// File: rtl/mx8_rr_arbiter.sv
// mx8_rr_arbiter: round-robin owner of the shared 8-to-1 mux select, with release/drop/hold-timeout
module mx8_rr_arbiter
  import mx8_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             rel,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);
  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick_ptr, idx;
  logic [NREQ-1:0] gnt_n, pick_mask;
  logic [HW-1:0] hold_cnt, cnt_n;
  logic found, lim, drop, done, to_n;
  assign pick_ptr = (state == GRANT) ? sel + SEL_W'(1) : ptr;
  assign pick_mask = (state == GRANT) ? ~gnt : '1;
  rr_pick8 u_pick (.req(req), .ptr(pick_ptr), .mask(pick_mask), .found(found), .idx(idx));
  assign lim = (HOLD_MAX != 0) && (hold_cnt == HW'(HOLD_MAX - 1));
  assign drop = !req[sel];
  assign done = rel | drop | lim;
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    sel_n = sel;
    ptr_n = ptr;
    cnt_n = hold_cnt;
    to_n = 1'b0;
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        gnt_n = onehot(idx);
        sel_n = idx;
        cnt_n = '0;
      end
    end else if (done) begin
      ptr_n = sel + SEL_W'(1);
      to_n = lim & !rel & !drop;
      cnt_n = '0;
      state_n = found ? GRANT : IDLE;
      gnt_n = found ? onehot(idx) : '0;
      sel_n = found ? idx : sel;
    end else begin
      cnt_n = hold_cnt + HW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      sel <= sel_n;
      busy <= |gnt_n;
      timeout <= to_n;
      ptr <= ptr_n;
      hold_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mx8_rr_arbiter.sv
// tb_mx8_rr_arbiter: directed vectors with hand-computed expectations for the round-robin arbiter
module tb_mx8_rr_arbiter;
  logic clk = 1'b0;
  logic reset, rel;
  logic [7:0] req, gnt;
  logic [2:0] sel;
  logic busy, timeout;
  int n = 0;
  int fails = 0;
  mx8_rr_arbiter #(.HOLD_MAX(15)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_onehot", 32'(gnt == 8'h00 || $onehot(gnt)), 32'd1);
    chk("inv_busy", 32'(busy), 32'(|gnt));
    if (gnt != 8'h00) chk("inv_sel", 32'(gnt), 32'(8'h01 << sel));
  endtask
  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s, input logic t);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_sel"}, 32'(sel), 32'(s));
    chk({tag, "_to"}, 32'(timeout), 32'(t));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    req = 8'h00;
    rel = 1'b0;
    step();
    do_reset();
    expect_out("reset", 8'h00, 3'd0, 1'b0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ptr", 32'(dut.ptr), 32'd0);
    req = 8'h01;
    step();
    expect_out("single", 8'h01, 3'd0, 1'b0);
    chk("single_busy", 32'(busy), 32'd1);
    rel = 1'b1;
    step();
    expect_out("single_rel", 8'h00, 3'd0, 1'b0);
    chk("single_rel_ptr", 32'(dut.ptr), 32'd1);
    req = 8'h00;
    rel = 1'b0;
    step();
    chk("idle_gnt", 32'(gnt), 32'd0);
    do_reset();
    req = 8'hFF;
    step();
    expect_out("rr0", 8'h01, 3'd0, 1'b0);
    rel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      expect_out($sformatf("rr%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b0);
    end
    req = 8'h00;
    rel = 1'b0;
    step();
    expect_out("rr_end", 8'h00, 3'd0, 1'b0);
    chk("rr_end_ptr", 32'(dut.ptr), 32'd1);
    do_reset();
    req = 8'h24;
    step();
    expect_out("hold_start", 8'h04, 3'd2, 1'b0);
    for (int k = 1; k < 15; k++) begin
      step();
      expect_out($sformatf("hold%0d", k), 8'h04, 3'd2, 1'b0);
    end
    step();
    expect_out("hold_timeout", 8'h20, 3'd5, 1'b1);
    step();
    expect_out("hold_after", 8'h20, 3'd5, 1'b0);
    chk("hold_after_cnt", 32'(dut.hold_cnt), 32'd1);
    do_reset();
    req = 8'h08;
    step();
    expect_out("drop_start", 8'h08, 3'd3, 1'b0);
    req = 8'h48;
    step();
    expect_out("no_preempt", 8'h08, 3'd3, 1'b0);
    req = 8'h40;
    step();
    expect_out("drop", 8'h40, 3'd6, 1'b0);
    chk("drop_ptr", 32'(dut.ptr), 32'd4);
    do_reset();
    req = 8'h80;
    step();
    expect_out("sole_start", 8'h80, 3'd7, 1'b0);
    for (int k = 1; k < 15; k++) step();
    chk("sole_hold_gnt", 32'(gnt), 32'h80);
    step();
    expect_out("sole_timeout", 8'h00, 3'd7, 1'b1);
    chk("sole_ptr_wrap", 32'(dut.ptr), 32'd0);
    step();
    expect_out("sole_regrant", 8'h80, 3'd7, 1'b0);
    for (int k = 0; k < 9; k++) step();
    chk("mid_cnt", 32'(dut.hold_cnt), 32'd9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_out("mid_reset", 8'h00, 3'd0, 1'b0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_ptr", 32'(dut.ptr), 32'd0);
    chk("mid_reset_cnt", 32'(dut.hold_cnt), 32'd0);
    req = 8'h24;
    step();
    expect_out("coinc_start", 8'h04, 3'd2, 1'b0);
    for (int k = 1; k < 15; k++) step();
    chk("coinc_cnt", 32'(dut.hold_cnt), 32'd14);
    rel = 1'b1;
    step();
    expect_out("coinc_rel", 8'h20, 3'd5, 1'b0);
    rel = 1'b0;
    req = 8'h00;
    step();
    expect_out("final_idle", 8'h00, 3'd5, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
